// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add MUL sequencer beside the EX-stage ALU.
// Stalls the pipeline for WIDTH+1 cycles, then pulses Done with Result.
module mul_sequencer #(
  parameter int          WIDTH      = 32,
  parameter logic [3:0]  ALUCON_MUL = 4'b0010
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid,
  input  logic [3:0]       ALUcon,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic [CW-1:0]    cnt;
  logic             start;
  logic             last;

  assign start  = Valid && (ALUcon == ALUCON_MUL);
  assign last   = (cnt == LAST);
  assign acc_nx = mplier[0] ? acc + mcand : acc;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Flush and reset both drop Stall in the same cycle
  always_comb begin
    state_nx = state;
    Stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          Stall    = 1'b1;
        end
      end
      RUN: begin
        Stall = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (Flush) begin
      state_nx = IDLE;
      Stall    = 1'b0;
    end
    if (!Rst) Stall = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      Result <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Busy <= (state_nx == RUN);
      Done <= (state_nx == DONE);
      if (state == IDLE && start && !Flush) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN && !Flush) begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last) Result <= acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer.
// Expected products are queued at issue and popped on Done.
module tb_mul_sequencer;

  localparam int W = 32;
  localparam logic [3:0] MUL = 4'b0010;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Valid;
  logic [3:0]   ALUcon;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Flush;
  logic         Stall;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] sb[$];
  logic [W-1:0] last_res;
  time          done_t;

  always #5 Clk = ~Clk;

  mul_sequencer #(.WIDTH(W), .ALUCON_MUL(MUL)) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Valid  (Valid),
    .ALUcon (ALUcon),
    .A      (A),
    .B      (B),
    .Flush  (Flush),
    .Stall  (Stall),
    .Busy   (Busy),
    .Done   (Done),
    .Result (Result)
  );

  function automatic logic [W-1:0] model(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  task automatic bubble();
    @(negedge Clk);
    Valid  = 1'b0;
    ALUcon = 4'b0000;
    Flush  = 1'b0;
  endtask

  task automatic do_mul(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input string        tag
  );
    int cyc;
    int stalls;
    int busys;
    bit seen;
    logic [W-1:0] exp;
    @(negedge Clk);
    Valid  = 1'b1;
    ALUcon = MUL;
    A      = a;
    B      = b;
    Flush  = 1'b0;
    sb.push_back(model(a, b));
    cyc = 0; stalls = 0; busys = 0; seen = 0;
    while (!seen && cyc < 100) begin
      #1;
      if (Done === 1'b1) seen = 1;
      else begin
        if (Stall === 1'b1) stalls++;
        if (Busy === 1'b1) busys++;
        @(negedge Clk);
        cyc++;
        A = $urandom;
        B = $urandom;
      end
    end
    exp = sb.pop_front();
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout got no Done in %0d cycles", tag, cyc);
    end else begin
      done_t = $time;
      checks++;
      if (cyc !== W + 1) begin
        errors++;
        $display("FAIL %s_latency got %0d want %0d", tag, cyc, W + 1);
      end
      checks++;
      if (stalls !== W + 1) begin
        errors++;
        $display("FAIL %s_stall_cycles got %0d want %0d", tag, stalls, W + 1);
      end
      checks++;
      if (busys !== W) begin
        errors++;
        $display("FAIL %s_busy_cycles got %0d want %0d", tag, busys, W);
      end
      checks++;
      if ({Stall, Busy} !== 2'b00) begin
        errors++;
        $display("FAIL %s_done_stall_busy got %b want 00", tag, {Stall, Busy});
      end
      checks++;
      if (Result !== exp) begin
        errors++;
        $display("FAIL %s_result got %h want %h", tag, Result, exp);
      end
    end
    last_res = exp;
  endtask

  task automatic test_reset();
    Rst    = 1'b0;
    Valid  = 1'b1;
    ALUcon = MUL;
    A      = 32'd5;
    B      = 32'd5;
    Flush  = 1'b0;
    last_res = '0;
    @(negedge Clk);
    #1;
    checks++;
    if ({Stall, Busy, Done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {Stall, Busy, Done});
    end
    checks++;
    if (Result !== '0) begin
      errors++;
      $display("FAIL reset_result got %h want 0", Result);
    end
    bubble();
    Rst = 1'b1;
    bubble();
  endtask

  task automatic test_basic();
    do_mul(32'd7, 32'd6, "mul_7x6");
    bubble();
    do_mul(32'hFFFF_FFFD, 32'd5, "mul_neg3x5");
    bubble();
    do_mul(32'h8000_0000, 32'hFFFF_FFFF, "mul_min_x_neg1");
    bubble();
    for (int i = 0; i < 3; i++) begin
      do_mul($urandom, $urandom, "mul_rand");
      bubble();
    end
  endtask

  task automatic test_back_to_back();
    time t1;
    do_mul(32'd123, 32'd456, "b2b_first");
    t1 = done_t;
    do_mul(32'hDEAD_BEEF, 32'h0000_1234, "b2b_second");
    checks++;
    if (done_t - t1 !== 340) begin
      errors++;
      $display("FAIL b2b_gap got %0t want 340", done_t - t1);
    end
    bubble();
  endtask

  task automatic test_flush();
    logic [W-1:0] prev;
    int dones;
    prev = last_res;
    @(negedge Clk);
    Valid  = 1'b1;
    ALUcon = MUL;
    A      = 32'd99;
    B      = 32'd77;
    for (int i = 0; i < 10; i++) @(negedge Clk);
    Flush = 1'b1;
    #1;
    checks++;
    if (Stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %b want 0", Stall);
    end
    bubble();
    #1;
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy got %b want 0", Busy);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      #1;
      if (Done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL flush_no_done got %0d want 0", dones);
    end
    checks++;
    if (Result !== prev) begin
      errors++;
      $display("FAIL flush_result got %h want %h", Result, prev);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge Clk);
    Valid  = 1'b1;
    ALUcon = MUL;
    A      = 32'h1234_5678;
    B      = 32'd9;
    for (int i = 0; i < 5; i++) @(negedge Clk);
    Rst = 1'b0;
    #1;
    checks++;
    if ({Stall, Busy, Done} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_flags got %b want 000", {Stall, Busy, Done});
    end
    checks++;
    if (Result !== '0) begin
      errors++;
      $display("FAIL rst_mid_result got %h want 0", Result);
    end
    last_res = '0;
    bubble();
    Rst = 1'b1;
    do_mul(32'd3, 32'd4, "mul_after_rst");
    bubble();
  endtask

  task automatic test_non_mul();
    int stalls;
    int dones;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk);
      Valid  = (k == 0);
      ALUcon = (k == 0) ? 4'b0000 : MUL;
      A      = 32'd11;
      B      = 32'd13;
      stalls = 0;
      dones  = 0;
      for (int i = 0; i < 20; i++) begin
        #1;
        if (Stall === 1'b1) stalls++;
        if (Done === 1'b1) dones++;
        @(negedge Clk);
      end
      checks++;
      if (stalls !== 0) begin
        errors++;
        $display("FAIL nonmul%0d_stall got %0d want 0", k, stalls);
      end
      checks++;
      if (dones !== 0) begin
        errors++;
        $display("FAIL nonmul%0d_done got %0d want 0", k, dones);
      end
    end
    bubble();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    test_non_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
